ahb_lite_master: RTL and testbench
==================================

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, haddr and cmd_addr width.
REQ-002 SHALL have parameter DATA_W, default 32, hwdata, hrdata, cmd_wdata and rsp_rdata width.
REQ-003 SHALL have port hclk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port hresetn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_write (in, 1), cmd_addr (in, ADDR_W) and cmd_wdata (in, DATA_W), forming the command request channel.
REQ-006 SHALL have ports rsp_valid (out, 1), rsp_write (out, 1) and rsp_rdata (out, DATA_W), forming the completion channel, with no backpressure.
REQ-007 SHALL have ports htrans (out, 2), hwrite (out, 1), haddr (out, ADDR_W) and hwdata (out, DATA_W), forming the AHB-Lite master outputs.
REQ-008 SHALL have ports hready (in, 1) and hrdata (in, DATA_W), forming the AHB-Lite slave response.

Function
REQ-009 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-010 SHALL register every AHB output; no combinational path SHALL exist from cmd_* to htrans, haddr, hwrite or hwdata.
REQ-011 SHALL advance the address phase only on an edge with hready=1:
  - load the next pending command: htrans=NONSEQ (2'b10), haddr=cmd_addr, hwrite=cmd_write;
  - if no command is pending, load htrans=IDLE (2'b00), haddr=0, hwrite=0.
REQ-012 SHALL hold htrans, haddr and hwrite unchanged while hready=0.
REQ-013 SHALL move a NONSEQ address phase to the data phase on the same hready=1 edge that completes the previous data phase, giving one transfer per cycle back-to-back.
REQ-014 SHALL drive hwdata with the stored write data for the whole write data phase, including every wait-state cycle; outside a write data phase hwdata SHALL be 0.
REQ-015 SHALL complete a data phase on the first edge with hready=1, then pulse rsp_valid for exactly one cycle after that edge:
  - rsp_write gives the transfer direction;
  - for reads, rsp_rdata = hrdata sampled on the completing edge;
  - for writes, rsp_rdata = 0.
REQ-016 SHALL return responses in command order and never issue BUSY or SEQ.
REQ-017 SHALL produce no response for an IDLE data phase.
REQ-018 SHALL drive cmd_ready = hready combinationally when CMD_FIFO is compiled out.

Reset
REQ-019 SHALL, while hresetn=0, hold htrans=IDLE, haddr=0, hwrite=0, hwdata=0, rsp_valid=0, rsp_write=0 and rsp_rdata=0, and empty the FIFO when present.
REQ-020 SHALL discard any in-flight address or data phase when reset is asserted mid-transfer, with no response for it.
REQ-021 SHALL issue the first NONSEQ no earlier than the second rising edge after hresetn deasserts.

Configuration
REQ-022 SHALL, with macro AHB_LITE_MASTER_CMD_FIFO_EN defined, place a 2-entry command FIFO before the address phase, behaving as follows:
  - cmd_ready = !full, independent of hready;
  - pop on an address-advance edge (REQ-011);
  - one extra cycle of command-to-bus latency;
  - a push and a pop on the same edge when full is allowed only if the pop frees a slot first, i.e. cmd_ready stays 0 when full.
REQ-023 SHALL, without AHB_LITE_MASTER_CMD_FIFO_EN, have no FIFO and follow REQ-018; the command is on the bus the cycle after acceptance.

Structure
REQ-024 SHALL take from shared package ahb_pkg:
  - htrans_t enum (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - ahb_cmd_t struct {write, addr, wdata}.
REQ-025 SHALL place the FIFO in a sub-module ahb_cmd_fifo, instantiated only under AHB_LITE_MASTER_CMD_FIFO_EN.

Verification
REQ-026 SHALL cover reset: hresetn=0 for 5 cycles with hready=1 -> htrans=0, haddr=0, hwrite=0, hwdata=0, rsp_valid=0 throughout.
REQ-027 SHALL cover a single write: write addr 0x0d, data 0x5a5a5a5a, hready=1 -> NONSEQ with haddr=0x0d and hwrite=1 for one cycle; then IDLE with hwdata=0x5a5a5a5a; then rsp_valid=1 with rsp_write=1; hwdata=0 afterwards.
REQ-028 SHALL cover a read with one wait state: read addr 0xf8, hready=0 for one data-phase cycle, hrdata=0xdfe -> rsp_valid=1 exactly once, with rsp_rdata=0xdfe two cycles after the address phase.
REQ-029 SHALL cover back-to-back reads: 3 reads at 0x10, 0x0c, 0x04 with hready=1 -> NONSEQ on 3 consecutive cycles and 3 consecutive rsp_valid pulses in order.
REQ-030 SHALL cover write wait states plus a pipelined read: write 0xfc/0xff with hready=0 for 8 cycles, followed by a read of 0xfc -> hwdata=0xff held all 8 cycles; haddr=0xfc and hwrite=0 held during the stall.
REQ-031 SHALL cover reset mid-transfer: hresetn asserted during a write data phase -> no rsp_valid, and all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types: transfer-type encoding and the packed command record.
// The command record is sized for the widest supported bus (32-bit address,
// 64-bit data); narrower masters zero-extend into it and slice back out.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam int AHB_MAX_ADDR_W = 32;
    localparam int AHB_MAX_DATA_W = 64;

    typedef struct packed {
        logic                      write;
        logic [AHB_MAX_ADDR_W-1:0] addr;
        logic [AHB_MAX_DATA_W-1:0] wdata;
    } ahb_cmd_t;

    localparam int AHB_CMD_W = $bits(ahb_cmd_t);

endpackage

// File: rtl/ahb_cmd_fifo.sv
// Purpose: 2-entry command FIFO in front of the AHB address phase.
// Latency: an entry pushed on an edge is visible at pop_dat after that edge.
// Backpressure: push is ignored when full; pop is ignored when empty.
// Ports: clk/rst_n (async active-low, empties the FIFO), push/push_dat,
//        pop/pop_dat (head entry, valid while !empty), full, empty.
module ahb_cmd_fifo
    import ahb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [AHB_CMD_W-1:0] push_dat,
    input  logic                 pop,
    output logic [AHB_CMD_W-1:0] pop_dat,
    output logic                 full,
    output logic                 empty
);

    logic [AHB_CMD_W-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    // A full FIFO refuses the push even when a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage needs no reset: count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/ahb_lite_master.sv
// Purpose: single-transfer AHB-Lite master; turns commands into NONSEQ/IDLE
//          transfers and returns one in-order completion per transfer.
// Latency: command on the bus the cycle after acceptance (one more cycle with
//          AHB_LITE_MASTER_CMD_FIFO_EN); completion pulses the cycle after the
//          data phase finishes. Backpressure: cmd_ready follows hready (no FIFO)
//          or !full (FIFO); the completion channel cannot be stalled.
// Ports: hclk/hresetn, cmd_* request channel, rsp_* completion channel,
//        htrans/hwrite/haddr/hwdata master outputs, hready/hrdata slave inputs.
// Option macro: AHB_LITE_MASTER_CMD_FIFO_EN (ADDR_W <= 32, DATA_W <= 64).
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [ADDR_W-1:0] haddr,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic [DATA_W-1:0] hrdata
);

    // Next command waiting to enter the address phase.
    logic              pend_vld;
    logic              pend_write;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata;

`ifdef AHB_LITE_MASTER_CMD_FIFO_EN
    ahb_cmd_t             push_cmd;
    ahb_cmd_t             pop_cmd;
    logic [AHB_CMD_W-1:0] pop_raw;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;

    always_comb begin
        push_cmd                    = '0;
        push_cmd.write              = cmd_write;
        push_cmd.addr[ADDR_W-1:0]   = cmd_addr;
        push_cmd.wdata[DATA_W-1:0]  = cmd_wdata;
    end

    assign fifo_push = cmd_valid && !fifo_full;
    assign fifo_pop  = hready && !fifo_empty;

    ahb_cmd_fifo u_cmd_fifo (
        .clk      (hclk),
        .rst_n    (hresetn),
        .push     (fifo_push),
        .push_dat (push_cmd),
        .pop      (fifo_pop),
        .pop_dat  (pop_raw),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign pop_cmd    = ahb_cmd_t'(pop_raw);
    assign cmd_ready  = !fifo_full;
    assign pend_vld   = !fifo_empty;
    assign pend_write = pop_cmd.write;
    assign pend_addr  = pop_cmd.addr[ADDR_W-1:0];
    assign pend_wdata = pop_cmd.wdata[DATA_W-1:0];
`else
    // Without a FIFO the address phase only moves on hready, so a command can
    // only be taken on those edges.
    assign cmd_ready  = hready;
    assign pend_vld   = cmd_valid;
    assign pend_write = cmd_write;
    assign pend_addr  = cmd_addr;
    assign pend_wdata = cmd_wdata;
`endif

    htrans_t           htrans_q;
    logic [DATA_W-1:0] ap_wdata;   // write data travelling with the address phase
    logic              dp_vld;     // a NONSEQ transfer is in its data phase
    logic              dp_write;

    assign htrans = htrans_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            htrans_q  <= IDLE;
            haddr     <= '0;
            hwrite    <= 1'b0;
            hwdata    <= '0;
            ap_wdata  <= '0;
            dp_vld    <= 1'b0;
            dp_write  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            // Both pipeline stages move together on hready; while it is low
            // every bus output holds, including hwdata during write wait states.
            if (hready) begin
                if (dp_vld) begin
                    rsp_valid <= 1'b1;
                    rsp_write <= dp_write;
                    rsp_rdata <= dp_write ? '0 : hrdata;
                end
                dp_vld   <= (htrans_q == NONSEQ);
                dp_write <= hwrite;
                hwdata   <= ((htrans_q == NONSEQ) && hwrite) ? ap_wdata : '0;
                if (pend_vld) begin
                    htrans_q <= NONSEQ;
                    haddr    <= pend_addr;
                    hwrite   <= pend_write;
                    ap_wdata <= pend_wdata;
                end else begin
                    htrans_q <= IDLE;
                    haddr    <= '0;
                    hwrite   <= 1'b0;
                    ap_wdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: directed scenarios plus random traffic, checked by
// a transaction-level model (accepted-command queue, one data-phase slot).
module tb_ahb_lite_master;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [7:0]  haddr;
    logic [31:0] hwdata;
    logic        hready = 1'b1;
    logic [31:0] hrdata = '0;

    always #5 hclk = ~hclk;

    ahb_lite_master #(.ADDR_W(8), .DATA_W(32)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .hready    (hready),
        .hrdata    (hrdata)
    );

    typedef struct packed {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } cmd_s;

    int   checks = 0;
    int   errors = 0;
    cmd_s acc_q[$];     // accepted commands not yet seen on the bus
    logic dp_pend = 1'b0;
    cmd_s dp_cmd;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_htrans"}, htrans, 2'b00);
        check({tag, "_haddr"},  haddr, 8'h00);
        check({tag, "_hwrite"}, hwrite, 1'b0);
        check({tag, "_hwdata"}, hwdata, 32'h0);
        check({tag, "_rsp"},    {rsp_valid, rsp_write, rsp_rdata}, 34'h0);
    endtask

    // Asserted mid-cycle so the asynchronous clear is observable before any edge.
    task automatic do_reset(input int n);
        hresetn   = 1'b0;
        cmd_valid = 1'b0;
        hready    = 1'b1;
        #1;
        check_reset_vals("rst_async");
        acc_q.delete();
        dp_pend = 1'b0;
        repeat (n) begin
            @(posedge hclk);
            #1;
            check_reset_vals("rst_hold");
        end
        @(negedge hclk);
        hresetn = 1'b1;
    endtask

    // One clock: drive inputs at negedge, snapshot, then judge the edge.
    task automatic cycle(input logic v, input logic w, input logic [7:0] a,
                         input logic [31:0] d, input logic rdy, input logic [31:0] rd,
                         output logic acc);
        logic        s_acc;
        logic [1:0]  s_htrans;
        logic [7:0]  s_haddr;
        logic        s_hwrite;
        logic [31:0] s_hwdata;
        logic        rsp_exp;
        logic        exp_w;
        logic [31:0] exp_rd;
        cmd_s        nc;
        @(negedge hclk);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        hready    = rdy;
        hrdata    = rd;
        #1;
        s_acc    = v && cmd_ready;
        s_htrans = htrans;
        s_haddr  = haddr;
        s_hwrite = hwrite;
        s_hwdata = hwdata;
        check("hwdata", s_hwdata, (dp_pend && dp_cmd.write) ? dp_cmd.wdata : 32'h0);
        check("htrans_legal", (s_htrans == 2'b00) || (s_htrans == 2'b10), 1'b1);
        if (s_htrans == 2'b00) check("idle_addr", {s_hwrite, s_haddr}, 9'h0);
`ifndef AHB_LITE_MASTER_CMD_FIFO_EN
        check("cmd_ready", cmd_ready, rdy);
`endif
        @(posedge hclk);
        #1;
        rsp_exp = 1'b0;
        exp_w   = 1'b0;
        exp_rd  = '0;
        if (rdy) begin
            if (dp_pend) begin
                rsp_exp = 1'b1;
                exp_w   = dp_cmd.write;
                exp_rd  = dp_cmd.write ? 32'h0 : rd;
            end
            dp_pend = 1'b0;
            if (s_htrans == 2'b10) begin
                if (acc_q.size() == 0) begin
                    check("spurious_nonseq", 1'b1, 1'b0);
                end else begin
                    nc = acc_q.pop_front();
                    check("nonseq_cmd", {s_hwrite, s_haddr}, {nc.write, nc.addr});
                    dp_pend = 1'b1;
                    dp_cmd  = nc;
                end
            end
        end else begin
            check("stall_hold", {htrans, hwrite, haddr}, {s_htrans, s_hwrite, s_haddr});
        end
        if (s_acc) acc_q.push_back(cmd_s'{write: w, addr: a, wdata: d});
        check("rsp_valid", rsp_valid, rsp_exp);
        if (rsp_exp) check("rsp_data", {rsp_write, rsp_rdata}, {exp_w, exp_rd});
`ifndef AHB_LITE_MASTER_CMD_FIFO_EN
        if (s_acc) check("issue_latency", {htrans, hwrite, haddr}, {2'b10, w, a});
`endif
        acc = s_acc;
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) cycle(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 32'($urandom), acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic        hv;
        logic        hw;
        logic [7:0]  ha;
        logic [31:0] hd;
        logic        rdy;
        int          stall;

        // Reset held for 5 cycles with hready high.
        #2;
        do_reset(5);
        idle(2);

        // Single write.
        cycle(1'b1, 1'b1, 8'h0d, 32'h5a5a5a5a, 1'b1, 32'h0, acc);
        check("wr_accept", acc, 1'b1);
        idle(1);
`ifndef AHB_LITE_MASTER_CMD_FIFO_EN
        check("wr_dphase", {htrans, hwdata}, {2'b00, 32'h5a5a5a5a});
        idle(1);
        check("wr_rsp", {rsp_valid, rsp_write}, 2'b11);
`else
        idle(2);
`endif
        idle(1);
        check("wr_hwdata_after", hwdata, 32'h0);

        // Read with one data-phase wait state.
        cycle(1'b1, 1'b0, 8'hf8, 32'h0, 1'b1, 32'h0, acc);
        idle(1);
`ifdef AHB_LITE_MASTER_CMD_FIFO_EN
        idle(1);
`endif
        cycle(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0, acc);
        cycle(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 32'h00000dfe, acc);
        check("rd_wait_rdata", {rsp_valid, rsp_rdata}, {1'b1, 32'h00000dfe});
        idle(3);

        // Back-to-back reads.
        cycle(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 32'h0, acc);
        cycle(1'b1, 1'b0, 8'h0c, 32'h0, 1'b1, 32'h0, acc);
        cycle(1'b1, 1'b0, 8'h04, 32'h0, 1'b1, 32'h0, acc);
        idle(4);

        // Write with 8 wait states, read pipelined behind it.
        cycle(1'b1, 1'b1, 8'hfc, 32'h000000ff, 1'b1, 32'h0, acc);
        cycle(1'b1, 1'b0, 8'hfc, 32'h0, 1'b1, 32'h0, acc);
`ifdef AHB_LITE_MASTER_CMD_FIFO_EN
        idle(1);
`endif
        repeat (8) begin
            cycle(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'($urandom), acc);
            check("stall_wdata", hwdata, 32'h000000ff);
            check("stall_rdaddr", {htrans, hwrite, haddr}, {2'b10, 1'b0, 8'hfc});
        end
        idle(4);

        // Reset during a write data phase.
        cycle(1'b1, 1'b1, 8'h22, 32'hcafef00d, 1'b1, 32'h0, acc);
        idle(1);
`ifdef AHB_LITE_MASTER_CMD_FIFO_EN
        idle(1);
`endif
        do_reset(2);
        idle(3);

        // Random traffic with random wait states and occasional long stalls.
        hv    = 1'b0;
        hw    = 1'b0;
        ha    = '0;
        hd    = '0;
        stall = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                do_reset(3);
                hv = 1'b0;
            end
            if (!hv && ($urandom_range(0, 99) < 60)) begin
                hv = 1'b1;
                hw = 1'($urandom_range(0, 1));
                ha = 8'($urandom);
                hd = $urandom;
            end
            if (stall == 0 && $urandom_range(0, 99) < 3) stall = $urandom_range(3, 10);
            if (stall > 0) begin
                rdy = 1'b0;
                stall--;
            end else begin
                rdy = ($urandom_range(0, 99) < 75);
            end
            cycle(hv, hw, ha, hd, rdy, $urandom, acc);
            if (acc) hv = 1'b0;
        end
        idle(10);
        check("drain_queue", acc_q.size(), 0);
        check("drain_dphase", dp_pend, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
